// File: rtl/mutex_pkg.sv
// Shared types and the rotating-priority pick function for the rr_mutex arbiter.
package mutex_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } mutex_state_e;

    // Widest requester vector the pick function scans; N must not exceed this.
    localparam int MAX_N  = 32;
    localparam int PICK_W = 5;

    typedef struct packed {
        logic              valid;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First requesting index at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input int unsigned      ptr,
                                      input int unsigned      n);
        pick_t       res;
        int unsigned j;
        res.valid = 1'b0;
        res.idx   = {PICK_W{1'b0}};
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = ptr + i;
            if (j >= n) begin
                j = j - n;
            end else begin
                j = j;
            end
            if ((i < n) && !res.valid && req[j[PICK_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = j[PICK_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mutex_if.sv
// Request/grant bundle between N requesters (master) and the rr_mutex arbiter (slave).
interface rr_mutex_if #(
    parameter int N = 4
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          timeout;

    modport master (output req, input gnt, gnt_id, busy, timeout);
    modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/req_sync.sv
// N-bit request synchroniser chain; a depth of zero passes requests straight through.
module req_sync #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);
    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_s;
            assign unused_clk_s = clk ^ rst;
            assign dout = din;
        end else begin : g_chain
            logic [N-1:0] stage_r [STAGES];

            // Shift each request bit through the flop chain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_r[i] <= {N{1'b0}};
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/rr_mutex.sv
// N-way round-robin mutex: synchronised requests, four-phase grant FSM with a
// guaranteed idle gap between owners, and an optional hold-time watchdog.
module rr_mutex
    import mutex_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_MAX    = 0
) (
    input  logic      clk,
    input  logic      rst,
    rr_mutex_if.slave bus
);
    localparam int             IW       = (N > 1) ? $clog2(N) : 1;
    localparam int             CW       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0]  HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam bit             WD_EN    = (HOLD_MAX > 0);

    logic [N-1:0]  req_sync_s;
    pick_t         pick_s;
    logic          unused_pick_s;

    mutex_state_e  state_r,   state_nxt_s;
    logic [IW-1:0] ptr_r,     ptr_nxt_s;
    logic [IW-1:0] owner_r,   owner_nxt_s;
    logic [CW-1:0] cnt_r,     cnt_nxt_s;
    logic [N-1:0]  gnt_r,     gnt_nxt_s;
    logic [IW-1:0] gnt_id_r,  gnt_id_nxt_s;
    logic          busy_r;
    logic          timeout_r, timeout_nxt_s;

    req_sync #(
        .N      (N),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.req),
        .dout (req_sync_s)
    );

    assign pick_s        = rr_pick(MAX_N'(req_sync_s), 32'(ptr_r), 32'(N));
    assign unused_pick_s = ^pick_s.idx;

    // Next-state, grant, pointer and watchdog decisions.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        owner_nxt_s   = owner_r;
        cnt_nxt_s     = cnt_r;
        gnt_nxt_s     = gnt_r;
        gnt_id_nxt_s  = gnt_id_r;
        timeout_nxt_s = timeout_r;
        case (state_r)
            IDLE: begin
                gnt_nxt_s     = {N{1'b0}};
                timeout_nxt_s = 1'b0;
                if (pick_s.valid) begin
                    owner_nxt_s  = pick_s.idx[IW-1:0];
                    gnt_id_nxt_s = pick_s.idx[IW-1:0];
                    gnt_nxt_s    = ONE_HOT0 << pick_s.idx;
                    cnt_nxt_s    = {CW{1'b0}};
                    state_nxt_s  = GRANT;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            GRANT: begin
                if (req_sync_s[owner_r]) begin
                    state_nxt_s = GRANT;
                    if (cnt_r != HOLD_LIM) begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    timeout_nxt_s = WD_EN && (cnt_nxt_s == HOLD_LIM);
                end else begin
                    gnt_nxt_s     = {N{1'b0}};
                    timeout_nxt_s = 1'b0;
                    state_nxt_s   = RELEASE;
                    if (owner_r == LAST_IDX) begin
                        ptr_nxt_s = {IW{1'b0}};
                    end else begin
                        ptr_nxt_s = owner_r + IW'(1);
                    end
                end
            end
            // One forced empty cycle so owners never appear back to back.
            RELEASE: begin
                gnt_nxt_s     = {N{1'b0}};
                timeout_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
            default: begin
                gnt_nxt_s     = {N{1'b0}};
                timeout_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            owner_r   <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            gnt_r     <= {N{1'b0}};
            gnt_id_r  <= {IW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            owner_r   <= owner_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gnt_r     <= gnt_nxt_s;
            gnt_id_r  <= gnt_id_nxt_s;
            busy_r    <= |gnt_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;
endmodule

// File: tb/tb_rr_mutex.sv
// Bench for rr_mutex: a synchronised/watchdog instance and a bypass/no-watchdog
// instance share one request vector and are compared against a queue-free reference model.
module tb_rr_mutex;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    int vectors = 0;
    int miscompares = 0;

    rr_mutex_if #(.N(4)) if_a ();
    rr_mutex_if #(.N(4)) if_b ();
    assign if_a.req = req;
    assign if_b.req = req;

    rr_mutex #(.N(4), .SYNC_STAGES(2), .HOLD_MAX(8)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    rr_mutex #(.N(4), .SYNC_STAGES(0), .HOLD_MAX(0)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, request history, current owner (-1 = none),
    // pointer, post-release gap and cycles held.
    int         m_s  [2] = '{2, 0};
    int         m_hm [2] = '{8, 0};
    int         m_owner [2];
    int         m_ptr   [2];
    int         m_gap   [2];
    int         m_held  [2];
    logic [3:0] m_hist  [2][3];

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_ptr[d] = 0; m_gap[d] = 0; m_held[d] = 0;
            for (int k = 0; k < 3; k++) m_hist[d][k] = 4'b0000;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        logic [3:0] rs;
        for (int k = 2; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = r;
        rs = m_hist[d][m_s[d]];
        if (m_owner[d] >= 0) begin
            if (rs[m_owner[d]]) m_held[d] = m_held[d] + 1;
            else begin
                m_ptr[d] = (m_owner[d] + 1) % 4;
                m_owner[d] = -1;
                m_gap[d] = 1;
            end
        end else if (m_gap[d] > 0) begin
            m_gap[d] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner[d] < 0 && rs[(m_ptr[d] + k) % 4]) begin
                    m_owner[d] = (m_ptr[d] + k) % 4;
                    m_held[d] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
        logic [3:0] one;
        logic [3:0] eg;
        logic       et;
        string      p;
        one = 4'b0001;
        p   = (d == 0) ? "a" : "b";
        eg  = (m_owner[d] >= 0) ? (one << m_owner[d]) : 4'b0000;
        et  = (m_owner[d] >= 0) && (m_hm[d] > 0) && (m_held[d] >= m_hm[d]);
        chk({p, "_gnt"},     32'(g), 32'(eg));
        chk({p, "_busy"},    32'(b), 32'(eg != 4'b0000));
        chk({p, "_timeout"}, 32'(t), 32'(et));
        chk({p, "_onehot"},  32'($countones(g) <= 1), 32'(1));
        if (m_owner[d] >= 0) chk({p, "_gnt_id"}, 32'(id), 32'(m_owner[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req);
        model_step(1, req);
        #1;
        check_dut(0, if_a.gnt, if_a.gnt_id, if_a.busy, if_a.timeout);
        check_dut(1, if_b.gnt, if_b.gnt_id, if_b.busy, if_b.timeout);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_a_gnt"},  32'(if_a.gnt),    32'(0));
        chk({name, "_a_id"},   32'(if_a.gnt_id), 32'(0));
        chk({name, "_a_busy"}, 32'(if_a.busy),   32'(0));
        chk({name, "_a_to"},   32'(if_a.timeout),32'(0));
        chk({name, "_b_gnt"},  32'(if_b.gnt),    32'(0));
        chk({name, "_b_busy"}, 32'(if_b.busy),   32'(0));
    endtask

    task automatic do_reset();
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;
    vec_t tbl [27];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         order[$];
        int         hc[4];
        int         zero_run;
        logic [3:0] prev_g;
        int         exp_order[5] = '{0, 1, 2, 3, 0};

        req = 4'b0000;
        rst = 1'b1;
        m_reset();
        #12;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Single requester, then fairness with the pointer at 3 and 2, then at 0.
        tbl[0]  = '{4'b0100, 4'b0000, 2'd0};
        tbl[1]  = '{4'b0100, 4'b0000, 2'd0};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[3]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[4]  = '{4'b0000, 4'b0100, 2'd2};
        tbl[5]  = '{4'b0000, 4'b0100, 2'd2};
        tbl[6]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[8]  = '{4'b0010, 4'b0000, 2'd0};
        tbl[9]  = '{4'b0010, 4'b0000, 2'd0};
        tbl[10] = '{4'b0010, 4'b0010, 2'd1};
        tbl[11] = '{4'b1011, 4'b0010, 2'd1};
        tbl[12] = '{4'b1001, 4'b0010, 2'd1};
        tbl[13] = '{4'b1001, 4'b0010, 2'd1};
        tbl[14] = '{4'b1001, 4'b0000, 2'd0};
        tbl[15] = '{4'b1001, 4'b0000, 2'd0};
        tbl[16] = '{4'b1001, 4'b1000, 2'd3};
        tbl[17] = '{4'b0001, 4'b1000, 2'd3};
        tbl[18] = '{4'b0001, 4'b1000, 2'd3};
        tbl[19] = '{4'b0001, 4'b0000, 2'd0};
        tbl[20] = '{4'b0001, 4'b0000, 2'd0};
        tbl[21] = '{4'b0001, 4'b0001, 2'd0};
        tbl[22] = '{4'b0000, 4'b0001, 2'd0};
        tbl[23] = '{4'b0000, 4'b0001, 2'd0};
        tbl[24] = '{4'b0000, 4'b0000, 2'd0};
        tbl[25] = '{4'b0000, 4'b0000, 2'd0};
        tbl[26] = '{4'b0000, 4'b0000, 2'd0};
        for (int i = 0; i < 27; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(if_a.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_to", i), 32'(if_a.timeout), 32'(0));
            if (tbl[i].gnt != 4'b0000)
                chk($sformatf("tbl%0d_id", i), 32'(if_a.gnt_id), 32'(tbl[i].id));
        end

        // Contention: all four requesting, each owner releasing after 4 granted cycles.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) hc[i] = 0;
        zero_run = 0;
        prev_g = 4'b0000;
        for (int c = 0; c < 300 && order.size() < 5; c++) begin
            tick();
            if (if_a.gnt == 4'b0000) zero_run++;
            else if (prev_g == 4'b0000) begin
                if (order.size() > 0) chk("handover_gap", 32'(zero_run >= 2), 32'(1));
                for (int i = 0; i < 4; i++) if (if_a.gnt[i]) order.push_back(i);
                zero_run = 0;
            end
            prev_g = if_a.gnt;
            for (int i = 0; i < 4; i++) begin
                if (if_a.gnt[i]) begin
                    hc[i]++;
                    if (hc[i] >= 4) req[i] = 1'b0;
                end else begin
                    hc[i] = 0;
                    req[i] = 1'b1;
                end
            end
        end
        chk("order_len", 32'(order.size()), 32'(5));
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("order%0d", i), 32'(order[i]), 32'(exp_order[i]));

        // Watchdog: hold 12 cycles; timeout from the 8th cycle until the grant drops.
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 10 && !if_a.gnt[0]; k++) tick();
        chk("wd_grant", 32'(if_a.gnt), 32'(4'b0001));
        for (int j = 1; j <= 16; j++) begin
            if (j == 12) req = 4'b0000;
            tick();
            chk($sformatf("wd_gnt_%0d", j), 32'(if_a.gnt), 32'((j < 14) ? 4'b0001 : 4'b0000));
            chk($sformatf("wd_to_%0d", j), 32'(if_a.timeout), 32'((j >= 8) && (j < 14)));
            chk($sformatf("wd_off_%0d", j), 32'(if_b.timeout), 32'(0));
        end

        // Reset in the middle of a timed-out grant, then re-arbitrate from pointer 0.
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 12; k++) tick();
        chk("mid_gnt", 32'(if_a.gnt), 32'(4'b0010));
        chk("mid_to", 32'(if_a.timeout), 32'(1));
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("async_gnt", 32'(if_a.gnt), 32'(0));
        chk("async_busy", 32'(if_a.busy), 32'(0));
        chk("async_to", 32'(if_a.timeout), 32'(0));
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("rst_regrant", 32'(if_a.gnt), 32'(4'b0010));

        // Bypass instance: next-edge grant, and a request withdrawn before it is served.
        do_reset();
        req = 4'b1000;
        tick();
        chk("byp_gnt", 32'(if_b.gnt), 32'(4'b1000));
        req = 4'b1001; tick();
        req = 4'b1000; tick();
        req = 4'b0000; tick();
        tick();
        tick();
        chk("byp_withdraw", 32'(if_b.gnt), 32'(0));

        // Randomised four-phase traffic checked against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
